// File: rtl/write_back_buffer.sv
// Write-back buffer between the L1 eviction port and the RAM write port.
// Dirty victims queue in a small circular FIFO. A repeat address coalesces in
// place unless that entry is already being written to RAM. Entries drain one
// at a time over a req/ack handshake. A snoop port returns the newest pending
// data for an address.
module write_back_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   evictValid,
  input  logic [ADDR_W-1:0]      evictAddr,
  input  logic [DATA_W-1:0]      evictData,
  output logic                   evictReady,
  output logic                   ramReq,
  output logic [ADDR_W-1:0]      ramAddr,
  output logic [DATA_W-1:0]      ramData,
  input  logic                   ramAck,
  input  logic [ADDR_W-1:0]      snoopAddr,
  output logic                   snoopHit,
  output logic [DATA_W-1:0]      snoopData,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {IDLE, SEND} state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       head_q, head_d;
  logic [PW-1:0]       tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [ADDR_W-1:0]   addr_q [DEPTH];
  logic [ADDR_W-1:0]   addr_d [DEPTH];
  logic [DATA_W-1:0]   data_q [DEPTH];
  logic [DATA_W-1:0]   data_d [DEPTH];
  logic                ram_req_q, ram_req_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_data_q, ram_data_d;
  logic                overflow_q, overflow_d;

  logic                not_full;
  logic                pop;
  logic                coal_hit;
  logic [PW-1:0]       coal_idx;
  logic                alloc;
  logic                drop;
  logic [PW-1:0]       snoop_idx;

  assign not_full   = (count_q < CW'(DEPTH));
  assign pop        = (state_q == SEND) && ramAck;
  assign evictReady = not_full;
  assign ramReq     = ram_req_q;
  assign ramAddr    = ram_addr_q;
  assign ramData    = ram_data_q;
  assign count      = count_q;
  assign overflow   = overflow_q;

  // Find a coalescing target: any valid entry except the head while it is in flight.
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == evictAddr) &&
          !((state_q == SEND) && (PW'(i) == head_q))) begin
        coal_hit = 1'b1;
        coal_idx = PW'(i);
      end
    end
  end

  assign alloc = evictValid && !coal_hit && not_full;
  assign drop  = evictValid && !coal_hit && !not_full;

  // Next-state logic for storage, pointers, count and the RAM handshake FSM.
  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    valid_d    = valid_q;
    addr_d     = addr_q;
    data_d     = data_q;
    ram_req_d  = ram_req_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    overflow_d = overflow_q;

    if (evictValid && coal_hit) begin
      data_d[coal_idx] = evictData;
    end
    if (alloc) begin
      addr_d[tail_q]  = evictAddr;
      data_d[tail_q]  = evictData;
      valid_d[tail_q] = 1'b1;
      tail_d          = PW'(tail_q + 1'b1);
    end
    if (drop) begin
      overflow_d = 1'b1;
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = PW'(head_q + 1'b1);
    end
    count_d = CW'(count_q + CW'(alloc) - CW'(pop));

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          ram_req_d  = 1'b1;
          ram_addr_d = addr_q[head_q];
          // A same-edge coalesce into the launching head must reach RAM.
          ram_data_d = (evictValid && coal_hit && (coal_idx == head_q)) ?
                       evictData : data_q[head_q];
          state_d    = SEND;
        end
      end
      SEND: begin
        if (ramAck) begin
          ram_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards every pending entry and drops ramReq.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      ram_req_q  <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      overflow_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      ram_req_q  <= ram_req_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      overflow_q <= overflow_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  // Snoop: walk oldest to newest so the most recently allocated match wins.
  always_comb begin
    snoopHit  = 1'b0;
    snoopData = '0;
    snoop_idx = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      snoop_idx = PW'(head_q + PW'(k));
      if (valid_q[snoop_idx] && (addr_q[snoop_idx] == snoopAddr)) begin
        snoopHit  = 1'b1;
        snoopData = data_q[snoop_idx];
      end
    end
  end

endmodule
